mix_columns_seq: RTL
====================

# mix_columns_seq

Sequential, handshake-driven AES MixColumns engine. It replaces the single-cycle combinational transform with an iterative datapath that processes `COLS_PER_CYCLE` 32-bit columns per clock. Multiplication in GF(2^8) is fully reduced modulo x^8+x^4+x^3+x+1, and an inverse mode is available. It sits in the ALU's AES path between ShiftRows and AddRoundKey, with valid/ready on both sides.

## Interface
- `COLS_PER_CYCLE`, default 1: columns transformed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration `$error`.
- `BEATS` (localparam) = 4 / `COLS_PER_CYCLE`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `state_in` and `inv_in` are valid.
- `in_ready`  out  1  engine can accept a block.
- `state_in`  in  128  input state. Column c = bits [32c+31:32c]; row r of a column = bits [8r+7:8r].
- `inv_in`  in  1  0 selects forward MixColumns, 1 selects InvMixColumns.
- `out_valid`  out  1  `state_out` holds a finished block.
- `out_ready`  in  1  downstream accepts the block.
- `state_out`  out  128  transformed state, same layout as `state_in`.
- `busy`  out  1  high in the BUSY state.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`: latch `state_in` into the working register, latch the mode, clear the column counter `col_idx`, go to BUSY.
- **BUSY:**
  - Each cycle, columns `col_idx` .. `col_idx+COLS_PER_CYCLE-1` are replaced in place by their transform.
  - `col_idx` advances by `COLS_PER_CYCLE`.
  - On the beat that processes column 3, go to DONE.
- **DONE:**
  - `out_valid`=1; `state_out` is driven from the working register.
  - Stays in DONE with stable data while `out_ready`=0.
  - On `out_ready`=1, go to IDLE.
- `in_ready` is 0 in BUSY and DONE. A block offered in those states is not taken and must be held by the sender.
- **Forward transform** (a0..a3 = rows):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- **Inverse transform:** coefficients rotate the same way from {0e,0b,0d,09}.
- **GF(2^8) arithmetic:**
  - xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 0).
  - Every product is 8 bits and always reduced.
  - Higher coefficients are built from xtime chains.
- `state_out` is the working register in every state. Only the value during `out_valid` is meaningful.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `state_out`=0, `col_idx`=0.
- **Latency:** accept edge at cycle 0; `out_valid` rises at cycle `BEATS` (4, 2 or 1).
- **Minimum issue interval:** `BEATS`+2 cycles, with `out_ready` tied high.
- **Reset mid-operation:**
  - Asserting `rst_n` low in BUSY or DONE drops `out_valid` and `busy` immediately, with no clock needed.
  - The block in progress is discarded.
  - After release, the first accepted block starts cleanly.
- `inv_in` is sampled only on the accept edge. Later changes do not affect the block in flight.

## Configuration
- Macro: `MIXCOL_INV_EN`.
- **Defined:** `inv_in`=1 selects InvMixColumns, as above.
- **Undefined:**
  - The inverse datapath is not synthesised.
  - The `inv_in` port remains present but is ignored.
  - Every block is transformed forward.

## Structure
- **Package `aes_pkg`** holds:
  - the functions `gf_xtime` and `gf_mul` (8-bit, reduced);
  - the FSM state enum `mixcol_state_t`;
  - the constants `AES_POLY` = 8'h1b and `AES_STATE_W` = 128.
- **Sub-module `mix_column_word`:**
  - Combinational, one 32-bit column.
  - Inputs are `col_in` and `inv`; output is `col_out`.
  - Its inverse branch sits under `MIXCOL_INV_EN`.
  - The top instantiates `COLS_PER_CYCLE` copies in a generate loop.

## Test plan
- **FIPS-197 forward column, `COLS_PER_CYCLE`=1:**
  - Stimulus: all four columns = 32'h455313db, `inv_in`=0.
  - Response: every column of `state_out` = 32'hbca14d8e; `out_valid` at cycle 4.
- **Mixed columns, `COLS_PER_CYCLE`=4:**
  - Stimulus: columns {32'h5c220af2, 32'hd5d4d4d4, 32'hc6c6c6c6, 32'h01010101} (column 0 first).
  - Response: {32'h9d58dc9f, 32'hd6d7d5d5, 32'hc6c6c6c6, 32'h01010101}; `out_valid` at cycle 1.
- **Inverse, `MIXCOL_INV_EN` defined, `COLS_PER_CYCLE`=2:**
  - Stimulus: columns 32'hbca14d8e, `inv_in`=1.
  - Response: 32'h455313db; a forward-then-inverse random round trip returns the original state.
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles in DONE → `state_out` stable and `in_ready`=0 throughout.
  - A second block held on `in_valid` is accepted only after handoff.
- **Reset:** assert `rst_n` low during the second BUSY beat → `out_valid`=0 and `busy`=0 asynchronously; the next block's result is correct.
- **Macro undefined:** `inv_in`=1 with 32'h455313db columns → forward result 32'hbca14d8e.

Source files
------------

// File: rtl/aes_pkg.sv
// AES helpers shared by the MixColumns engine: GF(2^8) arithmetic,
// engine FSM encoding and state-width constants.
package aes_pkg;

  localparam logic [7:0] AES_POLY    = 8'h1b;
  localparam int         AES_STATE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mixcol_state_t;

  // Multiply by x, reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // General product built from an xtime chain; every partial term stays reduced.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = gf_xtime(p);
    end
    return r;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns on one 32-bit column (row r = bits [8r+7:8r]).
// The inverse branch is built only when MIXCOL_INV_EN is defined; otherwise
// the inv input is ignored and the column is always transformed forward.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [3:0][7:0] a;
  logic [3:0][7:0] fwd;

  assign a = col_in;

  // Row r uses coefficients {2,3,1,1} rotated so that 2 lands on row r.
  for (genvar r = 0; r < 4; r++) begin : g_fwd
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign fwd[r] = gf_xtime(a[r]) ^ gf_xtime(a[R1]) ^ a[R1] ^ a[R2] ^ a[R3];
  end

`ifdef MIXCOL_INV_EN
  logic [3:0][7:0] invb;

  // Same rotation with {0e,0b,0d,09}.
  for (genvar r = 0; r < 4; r++) begin : g_inv
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign invb[r] = gf_mul(a[r],  8'h0e) ^ gf_mul(a[R1], 8'h0b) ^
                     gf_mul(a[R2], 8'h0d) ^ gf_mul(a[R3], 8'h09);
  end

  assign col_out = inv ? invb : fwd;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign col_out    = fwd;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine with valid/ready on both sides.
// COLS_PER_CYCLE columns (1, 2 or 4) are transformed in place per BUSY beat;
// the finished block is held in DONE until out_ready.
// Optional feature: define MIXCOL_INV_EN to enable InvMixColumns via inv_in.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   inv_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         CPC_SAFE = (COLS_PER_CYCLE > 0) ? COLS_PER_CYCLE : 1;
  localparam int         BEATS    = 4 / CPC_SAFE;
  // First column of the final beat; reaching it means the block completes this cycle.
  localparam logic [1:0] LAST_IDX = 2'((BEATS - 1) * CPC_SAFE);
  localparam logic [1:0] IDX_STEP = 2'(CPC_SAFE);

  mixcol_state_t                    state;
  logic [3:0][31:0]                 work;
  logic [3:0][31:0]                 work_nxt;
  logic [1:0]                       col_idx;
  logic                             inv_q;
  logic [COLS_PER_CYCLE-1:0][31:0]  lane_in;
  logic [COLS_PER_CYCLE-1:0][31:0]  lane_out;

  // One column transformer per lane, fed from the current column group.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
    assign lane_in[i] = work[col_idx + 2'(i)];
    mix_column_word u_mcw (
      .col_in  (lane_in[i]),
      .inv     (inv_q),
      .col_out (lane_out[i])
    );
  end

  // Column c belongs to the group starting at (c - c%CPC) and sits in lane c%CPC.
  for (genvar c = 0; c < 4; c++) begin : g_wb
    localparam int         LANE = c % CPC_SAFE;
    localparam logic [1:0] GRP  = 2'(c - LANE);
    assign work_nxt[c] = (col_idx == GRP) ? lane_out[LANE] : work[c];
  end

  // Handshake FSM and in-place working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      work    <= '0;
      col_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work    <= state_in;
            col_idx <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work    <= work_nxt;
          col_idx <= col_idx + IDX_STEP;
          if (col_idx == LAST_IDX) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MIXCOL_INV_EN
  // Mode is captured only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            inv_q <= 1'b0;
    else if (state == ST_IDLE && in_valid) inv_q <= inv_in;
  end
`else
  logic unused_inv_in;
  assign unused_inv_in = inv_in;
  assign inv_q         = 1'b0;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_BUSY);
  assign out_valid = (state == ST_DONE);
  assign state_out = work;

endmodule
